// File: rtl/mac_acc_pkg.sv
// mac_acc_pkg
//   Shared definitions for the multi-lane accumulator.
//   - out_state_t : result buffer state (EMPTY / FULL)
//   - COUNT_W     : width of the per-window beat counter
//   - sat_add     : signed add of two sign-extended operands with overflow
//                   detection at a run-time width, optionally saturating
package mac_acc_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_t;

   localparam int COUNT_W   = 16;
   localparam int SAT_MAX_W = 64;

   typedef struct packed {
      logic                 ovf;
      logic [SAT_MAX_W-1:0] value;
   } sat_result_t;

   // Operands must already be sign-extended from 'width' bits to SAT_MAX_W.
   // Only value[width-1:0] is meaningful; the caller keeps that slice.
   function automatic sat_result_t sat_add(
      input logic [SAT_MAX_W-1:0] a,
      input logic [SAT_MAX_W-1:0] b,
      input logic [6:0]           width,
      input logic                 sat_en
   );
      logic [SAT_MAX_W:0]   sum;
      logic [SAT_MAX_W-1:0] half;
      sat_result_t          res;
      sum  = {a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b};
      // half = 2^(width-1): magnitude of the most negative value
      half = {{(SAT_MAX_W-1){1'b0}}, 1'b1} << (width - 7'd1);
      // The exact sum fits in width+1 bits; it is out of range when the
      // top two of those bits disagree.
      res.ovf = sum[width] ^ sum[width - 7'd1];
      if (res.ovf && sat_en) begin
         res.value = sum[width] ? (~half + 64'd1) : (half - 64'd1);
      end else begin
         res.value = sum[SAT_MAX_W-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/multi_channel_accumulator_lane.sv
// acc_lane
//   One signed accumulator lane: ACC_W+1 adder, saturate/wrap, accumulator
//   register and sticky overflow flag.
//   Ports:
//     clk, reset  : clock, asynchronous active-high reset
//     clear       : zero accumulator and flag (window abort)
//     en          : accept the current sample
//     load        : this accepted sample closes the window; the register
//                   restarts at zero while 'sum'/'ovf' carry the final value
//     sample      : signed input, DATA_W bits
//     sum         : accumulator value including the current sample
//     ovf         : sticky flag including the current sample
module acc_lane
   import mac_acc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 21,
   parameter int SAT_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              en,
   input  logic              load,
   input  logic [DATA_W-1:0] sample,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);

   logic [ACC_W-1:0]     acc_reg;
   logic                 flag_reg;
   sat_result_t          add_res;
   logic [SAT_MAX_W-1:ACC_W] upper_unused;

   always_comb begin
      add_res = sat_add({{(SAT_MAX_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg},
                        {{(SAT_MAX_W-DATA_W){sample[DATA_W-1]}}, sample},
                        7'(ACC_W), SAT_EN != 0);
   end

   assign sum          = add_res.value[ACC_W-1:0];
   assign upper_unused = add_res.value[SAT_MAX_W-1:ACC_W];
   assign ovf          = flag_reg | add_res.ovf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_reg  <= '0;
         flag_reg <= 1'b0;
      end else if (clear) begin
         acc_reg  <= '0;
         flag_reg <= 1'b0;
      end else if (en) begin
         acc_reg  <= load ? '0 : sum;
         flag_reg <= load ? 1'b0 : ovf;
      end
   end

endmodule

// File: rtl/multi_channel_accumulator.sv
// multi_channel_accumulator
//   NUM_CH signed accumulator lanes with window framing (in_last or a fixed
//   beat count), per-lane saturation and sticky overflow, and a one-entry
//   valid/ready result buffer.
//   Ports:
//     clk, reset            : clock, asynchronous active-high reset
//     clear_acc             : abort the current window (blocks input that cycle)
//     in_valid/in_ready     : input handshake
//     in_data, in_last      : packed lanes (k at [k*DATA_W +: DATA_W]), end of window
//     out_valid/out_ready   : result handshake
//     out_data              : packed lane sums (k at [k*ACC_W +: ACC_W])
//     out_ovf, out_count    : per-lane sticky overflow, beats in window
module multi_channel_accumulator
   import mac_acc_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int ACC_W   = 21,
   parameter int NUM_CH  = 4,
   parameter int WIN_LEN = 0,
   parameter int SAT_EN  = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear_acc,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH*ACC_W-1:0]  out_data,
   output logic [NUM_CH-1:0]        out_ovf,
   output logic [COUNT_W-1:0]       out_count
);

   out_state_t                state_reg;
   out_state_t                state_next;
   logic                      load_buf;
   logic                      accept;
   logic                      close;
   logic                      win_hit;
   logic [COUNT_W-1:0]        count_reg;
   logic [COUNT_W-1:0]        count_inc;
   logic [COUNT_W:0]          count_plus;
   logic [NUM_CH*ACC_W-1:0]   lane_sum;
   logic [NUM_CH-1:0]         lane_ovf;
   logic [NUM_CH*ACC_W-1:0]   data_reg;
   logic [NUM_CH-1:0]         ovf_reg;
   logic [COUNT_W-1:0]        count_out_reg;

   // Ready depends only on registered state and the abort strobe; a full
   // buffer can still take a beat when the consumer drains it this cycle.
   assign in_ready = !clear_acc && (state_reg == EMPTY || out_ready);
   assign accept   = in_valid && in_ready;

   // The unsaturated count+1 drives the auto-close compare, so a saturated
   // counter never spuriously matches.
   assign count_plus = {1'b0, count_reg} + {{COUNT_W{1'b0}}, 1'b1};
   assign count_inc  = (count_reg == {COUNT_W{1'b1}}) ? count_reg : count_plus[COUNT_W-1:0];
   assign win_hit    = (WIN_LEN != 0) && (count_plus == (COUNT_W+1)'(WIN_LEN));
   assign close      = accept && (in_last || win_hit);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
         acc_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SAT_EN (SAT_EN)
         ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .clear  (clear_acc),
            .en     (accept),
            .load   (close),
            .sample (in_data[gi*DATA_W +: DATA_W]),
            .sum    (lane_sum[gi*ACC_W +: ACC_W]),
            .ovf    (lane_ovf[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clear_acc) begin
         count_reg <= '0;
      end else if (accept) begin
         count_reg <= close ? '0 : count_inc;
      end
   end

   always_comb begin
      state_next = state_reg;
      load_buf   = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (close) begin
               state_next = FULL;
               load_buf   = 1'b1;
            end
         end
         FULL: begin
            // A close while full implies out_ready: replace without a bubble.
            if (close) begin
               load_buf = 1'b1;
            end else if (out_ready) begin
               state_next = EMPTY;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= EMPTY;
         data_reg      <= '0;
         ovf_reg       <= '0;
         count_out_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (load_buf) begin
            data_reg      <= lane_sum;
            ovf_reg       <= lane_ovf;
            count_out_reg <= count_inc;
         end
      end
   end

   assign out_valid = (state_reg == FULL);
   assign out_data  = data_reg;
   assign out_ovf   = ovf_reg;
   assign out_count = count_out_reg;

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// tb_multi_channel_accumulator
//   Three instances share the stimulus: default (saturating, in_last only),
//   wrapping (SAT_EN=0) and auto-close (WIN_LEN=5). 'sel' gates in_valid to
//   one instance and picks which outputs are observed.
module tb_multi_channel_accumulator;

   localparam int DATA_W = 16;
   localparam int ACC_W  = 21;
   localparam int NUM_CH = 4;
   localparam longint HI = (longint'(1) << (ACC_W-1)) - 1;
   localparam longint LO = -HI - 1;
   localparam longint SPAN = 2 * (HI + 1);

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clear_acc = 1'b0;
   logic in_valid = 1'b0;
   logic in_last = 1'b0;
   logic out_ready = 1'b0;
   logic [NUM_CH*DATA_W-1:0] in_data = '0;
   logic [1:0] sel = 2'd0;

   logic                    in_ready_d  [3];
   logic                    out_valid_d [3];
   logic [NUM_CH*ACC_W-1:0] out_data_d  [3];
   logic [NUM_CH-1:0]       out_ovf_d   [3];
   logic [15:0]             out_count_d [3];

   wire                    in_ready_s  = in_ready_d[sel];
   wire                    out_valid_s = out_valid_d[sel];
   wire [NUM_CH*ACC_W-1:0] out_data_s  = out_data_d[sel];
   wire [NUM_CH-1:0]       out_ovf_s   = out_ovf_d[sel];
   wire [15:0]             out_count_s = out_count_d[sel];

   always #5 clk = ~clk;

   multi_channel_accumulator dut_sat (
      .clk(clk), .reset(reset), .clear_acc(clear_acc),
      .in_valid(in_valid && sel == 2'd0), .in_ready(in_ready_d[0]),
      .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_d[0]), .out_ready(out_ready),
      .out_data(out_data_d[0]), .out_ovf(out_ovf_d[0]), .out_count(out_count_d[0])
   );

   multi_channel_accumulator #(.SAT_EN(0)) dut_wrap (
      .clk(clk), .reset(reset), .clear_acc(clear_acc),
      .in_valid(in_valid && sel == 2'd1), .in_ready(in_ready_d[1]),
      .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_d[1]), .out_ready(out_ready),
      .out_data(out_data_d[1]), .out_ovf(out_ovf_d[1]), .out_count(out_count_d[1])
   );

   multi_channel_accumulator #(.WIN_LEN(5)) dut_win (
      .clk(clk), .reset(reset), .clear_acc(clear_acc),
      .in_valid(in_valid && sel == 2'd2), .in_ready(in_ready_d[2]),
      .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_d[2]), .out_ready(out_ready),
      .out_data(out_data_d[2]), .out_ovf(out_ovf_d[2]), .out_count(out_count_d[2])
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NUM_CH*DATA_W-1:0] pack_in(input int a, input int b, input int c, input int d);
      int v[4];
      logic [NUM_CH*DATA_W-1:0] r;
      v = '{a, b, c, d};
      for (int k = 0; k < NUM_CH; k++) r[k*DATA_W +: DATA_W] = v[k][DATA_W-1:0];
      return r;
   endfunction

   function automatic logic [NUM_CH*ACC_W-1:0] pack_acc(input longint a, input longint b, input longint c, input longint d);
      longint v[4];
      logic [NUM_CH*ACC_W-1:0] r;
      v = '{a, b, c, d};
      for (int k = 0; k < NUM_CH; k++) r[k*ACC_W +: ACC_W] = v[k][ACC_W-1:0];
      return r;
   endfunction

   task automatic drive(input logic v, input logic l, input logic c, input logic r,
                        input logic [NUM_CH*DATA_W-1:0] d);
      in_valid  = v;
      in_last   = l;
      clear_acc = c;
      out_ready = r;
      in_data   = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- table-driven vectors ----------------
   typedef struct packed {
      logic v, l, c, r;
      logic [NUM_CH*DATA_W-1:0] data;
      logic exp_ready;
      logic exp_valid;
      logic [NUM_CH*ACC_W-1:0] exp_data;
      logic [15:0] exp_count;
   } vec_t;

   // Lane k carries (k+1)*d; expected lane k is (k+1)*e.
   function automatic vec_t mk(input logic v, input logic l, input logic c, input logic r, input int d,
                               input logic er, input logic ev, input int e, input logic [15:0] ec);
      vec_t t;
      t.v = v; t.l = l; t.c = c; t.r = r;
      t.data      = pack_in(d, 2*d, 3*d, 4*d);
      t.exp_ready = er;
      t.exp_valid = ev;
      t.exp_data  = pack_acc(e, 2*e, 3*e, 4*e);
      t.exp_count = ec;
      return t;
   endfunction

   // ---------------- behavioural reference model ----------------
   longint m_acc [4];
   bit [3:0] m_flag;
   int m_cnt;
   bit m_valid;
   longint m_res [4];
   bit [3:0] m_res_ovf;
   int m_res_cnt;

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_acc[k] = 0;
         m_res[k] = 0;
      end
      m_flag = '0; m_cnt = 0; m_valid = 0; m_res_ovf = '0; m_res_cnt = 0;
   endtask

   task automatic model_step(input bit v, input bit l, input bit c, input bit r,
                             input logic [NUM_CH*DATA_W-1:0] d, input bit sat, input int win,
                             output bit closed);
      bit rdy;
      logic signed [DATA_W-1:0] lane;
      longint s;
      rdy = !c && (!m_valid || r);
      closed = 0;
      if (c) begin
         for (int k = 0; k < 4; k++) m_acc[k] = 0;
         m_flag = '0;
         m_cnt = 0;
      end else if (v && rdy) begin
         for (int k = 0; k < 4; k++) begin
            lane = d[k*DATA_W +: DATA_W];
            s = m_acc[k] + longint'(lane);
            if (s > HI || s < LO) begin
               m_flag[k] = 1'b1;
               if (sat) s = (s > HI) ? HI : LO;
               else     s = (s > HI) ? s - SPAN : s + SPAN;
            end
            m_acc[k] = s;
         end
         if (m_cnt < 65535) m_cnt++;
         if (l || (win != 0 && m_cnt == win)) begin
            closed = 1;
            for (int k = 0; k < 4; k++) begin
               m_res[k] = m_acc[k];
               m_acc[k] = 0;
            end
            m_res_ovf = m_flag;
            m_res_cnt = m_cnt;
            m_flag = '0;
            m_cnt = 0;
         end
      end
      if (closed) m_valid = 1;
      else if (r) m_valid = 0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      vec_t vecs[11];
      bit closed;
      bit rv, rl, rc, rr;
      int dv[4];
      logic [NUM_CH*DATA_W-1:0] rd;

      // reset state while reset is held
      #2;
      check("rst out_valid", out_valid_s, 1'b0);
      check("rst out_data",  out_data_s, '0);
      check("rst out_ovf",   out_ovf_s, '0);
      check("rst out_count", out_count_s, '0);
      tick();
      reset = 1'b0;
      check("rst in_ready", in_ready_s, 1'b1);

      // basic window, clear, back-pressure with zero-bubble replacement
      vecs[0]  = mk(1, 0, 0, 1, 1, 1, 0, 0, 16'd0);
      vecs[1]  = mk(1, 0, 0, 1, 1, 1, 0, 0, 16'd0);
      vecs[2]  = mk(1, 1, 0, 1, 1, 1, 1, 3, 16'd3);
      vecs[3]  = mk(1, 0, 0, 1, 7, 1, 0, 0, 16'd0);
      vecs[4]  = mk(1, 0, 0, 1, 7, 1, 0, 0, 16'd0);
      vecs[5]  = mk(1, 1, 1, 1, 7, 0, 0, 0, 16'd0);
      vecs[6]  = mk(1, 1, 0, 1, 2, 1, 1, 2, 16'd1);
      vecs[7]  = mk(0, 0, 0, 0, 0, 0, 1, 2, 16'd1);
      vecs[8]  = mk(1, 1, 0, 0, 5, 0, 1, 2, 16'd1);
      vecs[9]  = mk(1, 1, 0, 1, 5, 1, 1, 5, 16'd1);
      vecs[10] = mk(0, 0, 0, 1, 0, 1, 0, 0, 16'd0);

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].v, vecs[i].l, vecs[i].c, vecs[i].r, vecs[i].data);
         @(negedge clk);
         check($sformatf("vec%0d in_ready", i), in_ready_s, vecs[i].exp_ready);
         tick();
         check($sformatf("vec%0d out_valid", i), out_valid_s, vecs[i].exp_valid);
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d out_data", i), out_data_s, vecs[i].exp_data);
            check($sformatf("vec%0d out_count", i), out_count_s, vecs[i].exp_count);
            check($sformatf("vec%0d out_ovf", i), out_ovf_s, '0);
         end
         $display("vec %0d: valid=%0b last=%0b clr=%0b rdy=%0b -> out_valid=%0b count=%0d",
                  i, vecs[i].v, vecs[i].l, vecs[i].c, vecs[i].r, out_valid_s, out_count_s);
      end

      // saturation (sel 0) and wrap (sel 1): 40 beats of 0x7FFF on lane 0
      for (int s = 0; s < 2; s++) begin
         sel = 2'(s);
         for (int i = 0; i < 40; i++) begin
            drive(1, i == 39, 0, 1, pack_in(32767, 0, 0, 0));
            tick();
         end
         check($sformatf("sat%0d out_valid", s), out_valid_s, 1'b1);
         check($sformatf("sat%0d out_data", s), out_data_s,
               pack_acc((s == 0) ? 64'h0FFFFF : 64'h13FFD8, 0, 0, 0));
         check($sformatf("sat%0d out_ovf", s), out_ovf_s, 4'b0001);
         check($sformatf("sat%0d out_count", s), out_count_s, 16'd40);
         $display("sat sel=%0d: lane0=%0h ovf=%0b count=%0d", s, out_data_s[ACC_W-1:0], out_ovf_s, out_count_s);
         drive(0, 0, 0, 1, '0);
         tick();
      end

      // auto-close after 5 beats, in_last never asserted
      sel = 2'd2;
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 0, 1, pack_in(1, 1, 1, 1));
         tick();
         check($sformatf("win beat%0d out_valid", i), out_valid_s, (i == 4 || i == 9));
         if (i == 4 || i == 9) begin
            check($sformatf("win beat%0d out_data", i), out_data_s, pack_acc(5, 5, 5, 5));
            check($sformatf("win beat%0d out_count", i), out_count_s, 16'd5);
            $display("win result at beat %0d: count=%0d", i, out_count_s);
         end
      end
      drive(0, 0, 0, 1, '0);
      tick();

      // asynchronous reset with a full, stalled buffer
      sel = 2'd0;
      drive(1, 1, 0, 0, pack_in(1, 2, 3, 4));
      tick();
      check("arst pre out_valid", out_valid_s, 1'b1);
      drive(0, 0, 0, 0, '0);
      #2 reset = 1'b1;
      #1;
      check("arst out_valid", out_valid_s, 1'b0);
      check("arst out_data",  out_data_s, '0);
      check("arst out_ovf",   out_ovf_s, '0);
      check("arst out_count", out_count_s, '0);
      #1 reset = 1'b0;
      tick();
      check("arst in_ready", in_ready_s, 1'b1);
      $display("async reset with full buffer: out_valid=%0b", out_valid_s);

      // reset mid-window: partial sum must be lost
      drive(1, 0, 0, 1, pack_in(4, 4, 4, 4));
      tick();
      tick();
      drive(0, 0, 0, 1, '0);
      #2 reset = 1'b1;
      #2 reset = 1'b0;
      tick();
      drive(1, 1, 0, 1, pack_in(-3, -3, -3, -3));
      tick();
      check("mid out_valid", out_valid_s, 1'b1);
      check("mid lane0", out_data_s[ACC_W-1:0], 21'h1FFFFD);
      check("mid out_data", out_data_s, pack_acc(-3, -3, -3, -3));
      check("mid out_count", out_count_s, 16'd1);
      $display("reset mid-window: lane0=%0h count=%0d", out_data_s[ACC_W-1:0], out_count_s);
      drive(0, 0, 0, 1, '0);
      tick();

      // randomized traffic against the reference model, each instance
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         pulse_reset();
         for (int n = 0; n < 500; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rl = (s == 2) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 39) == 0);
            rc = ($urandom_range(0, 49) == 0);
            rr = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 4; k++)
               dv[k] = ($urandom_range(0, 7) == 0) ? -int'($urandom_range(0, 32768))
                                                   : int'($urandom_range(20000, 32767));
            rd = pack_in(dv[0], dv[1], dv[2], dv[3]);
            drive(rv, rl, rc, rr, rd);
            @(negedge clk);
            check($sformatf("rnd%0d.%0d in_ready", s, n), in_ready_s, !rc && (!m_valid || rr));
            tick();
            model_step(rv, rl, rc, rr, rd, s != 1, (s == 2) ? 5 : 0, closed);
            check($sformatf("rnd%0d.%0d out_valid", s, n), out_valid_s, m_valid);
            if (m_valid) begin
               check($sformatf("rnd%0d.%0d out_data", s, n), out_data_s,
                     pack_acc(m_res[0], m_res[1], m_res[2], m_res[3]));
               check($sformatf("rnd%0d.%0d out_ovf", s, n), out_ovf_s, m_res_ovf);
               check($sformatf("rnd%0d.%0d out_count", s, n), out_count_s, 16'(m_res_cnt));
            end
            if (closed)
               $display("rnd sel=%0d cyc=%0d: result lane0=%0d ovf=%b count=%0d",
                        s, n, m_res[0], m_res_ovf, m_res_cnt);
         end
         drive(0, 0, 0, 1, '0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
